text_line_scheduler: RTL and testbench

- Arbitrates write access to the 8-bit-per-character text line buffer that the overlay character renderer reads through its char_xy address.
- Up to N_REQ requesters each stream a full line of LINE_CHARS character codes. The block grants one requester at a time using round-robin.
- Buffer writes happen only while vblnk_in is high, so the displayed text line never tears mid-frame.
- Sits between status/score producers and the character line RAM write port.

---
 rtl/text_line_scheduler.sv | 130 +++++++++++++
 tb/tb_text_line_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_line_scheduler.sv
// Round-robin arbiter that lets one producer at a time write a full text line
// into the character line buffer, with writes confined to vertical blanking.
module text_line_scheduler #(
    parameter int N_REQ      = 2,
    parameter int LINE_CHARS = 30,
    parameter int ADDR_W     = 5
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 vblnk_in,
    input  logic [N_REQ-1:0]     req_in,
    input  logic [N_REQ-1:0]     char_valid_in,
    input  logic [8*N_REQ-1:0]   char_data_in,
    output logic [N_REQ-1:0]     grant_out,
    output logic                 char_ready_out,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_CHARS - 1);
    localparam logic [SEL_W-1:0]  LAST_SEL  = SEL_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BLANK,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  pick;
    logic [SEL_W-1:0]  next_ptr;
    logic [ADDR_W-1:0] count;
    logic              any_req;
    logic              sel_req;
    logic              sel_valid;
    logic [7:0]        sel_data;
    logic              accept;

    // First requesting index at or after ptr, wrapping; the descending loop
    // lets the closest candidate overwrite farther ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req_in[idx]) pick = SEL_W'(idx);
        end
    end

    assign any_req   = |req_in;
    assign sel_req   = req_in[sel];
    assign sel_valid = char_valid_in[sel];
    assign sel_data  = char_data_in[{sel, 3'b000} +: 8];
    assign next_ptr  = (sel == LAST_SEL) ? '0 : sel + 1'b1;

    assign char_ready_out = (state == WRITE) & vblnk_in & sel_req;
    assign accept         = char_ready_out & sel_valid;
    assign busy_out       = (state != IDLE);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            ptr       <= '0;
            count     <= '0;
            grant_out <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done_out  <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel       <= pick;
                        grant_out <= N_REQ'(1) << pick;
                        count     <= '0;
                        state     <= WAIT_BLANK;
                    end
                end
                WAIT_BLANK: begin
                    if (!sel_req) begin
                        grant_out <= '0;
                        state     <= IDLE;
                    end else if (vblnk_in) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    // Abort keeps already-written characters and leaves ptr alone.
                    if (!sel_req) begin
                        grant_out <= '0;
                        state     <= IDLE;
                    end else if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= count;
                        wr_data <= sel_data;
                        if (count == LAST_ADDR) begin
                            grant_out <= '0;
                            done_out  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    ptr   <= next_ptr;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_line_scheduler.sv
// Directed bench for text_line_scheduler: stimulus pushes expected line-buffer
// writes into a queue, a negedge monitor pops and compares each wr_en cycle.
module tb_text_line_scheduler;

    localparam int N  = 2;
    localparam int LC = 30;
    localparam int AW = 5;

    logic           pclk = 1'b0;
    logic           rst  = 1'b1;
    logic           vblnk_in = 1'b0;
    logic [N-1:0]   req_in = '0;
    logic [N-1:0]   char_valid_in = '0;
    logic [8*N-1:0] char_data_in = '0;
    logic [N-1:0]   grant_out;
    logic           char_ready_out;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [7:0]     wr_data;
    logic           busy_out;
    logic           done_out;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic          done;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  done_count = 0;

    text_line_scheduler #(.N_REQ(N), .LINE_CHARS(LC), .ADDR_W(AW)) dut (
        .pclk           (pclk),
        .rst            (rst),
        .vblnk_in       (vblnk_in),
        .req_in         (req_in),
        .char_valid_in  (char_valid_in),
        .char_data_in   (char_data_in),
        .grant_out      (grant_out),
        .char_ready_out (char_ready_out),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy_out       (busy_out),
        .done_out       (done_out)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the oldest expected entry.
    always @(negedge pclk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", {27'b0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
                check("wr_data", {24'b0, wr_data}, {24'b0, e.data});
                check("wr_done", {31'b0, done_out}, {31'b0, e.done});
                if (done_out === 1'b1) done_count++;
            end
        end else if (done_out !== 1'b0 && !$isunknown(done_out)) begin
            check("done_stray", {31'b0, done_out}, 32'd0);
        end
    end

    // Feed requester r characters start..start+n-1; codes are 0x41+index.
    task automatic stream(input int r, input int start, input int n, input bit toggle);
        int k   = start;
        int cyc = 0;
        while (k < start + n && cyc < 400) begin
            // NOTE: bench inputs are driven with blocking assignments away
            // from the active edge, so the DUT never races the stimulus.
            char_valid_in    = '1;
            char_valid_in[r] = (!toggle || (cyc % 2 == 0));
            char_data_in     = {N{8'hEE}};
            char_data_in[8*r +: 8] = 8'(8'h41 + k);
            @(negedge pclk);
            if (char_ready_out && char_valid_in[r]) begin
                exp_q.push_back('{addr: AW'(k), data: 8'(8'h41 + k), done: (k == LC - 1)});
                k++;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        char_valid_in = '0;
        check("stream_accepts", k, start + n);
    endtask

    task automatic wait_grant(input logic [N-1:0] exp, input string name);
        int n = 0;
        @(negedge pclk);
        while (grant_out == '0 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        check(name, {30'b0, grant_out}, {30'b0, exp});
        check({name, "_ready_in_wait"}, {31'b0, char_ready_out}, 32'd0);
        check({name, "_busy"}, {31'b0, busy_out}, 32'd1);
        @(posedge pclk); #1;
    endtask

    // Called in the DONE cycle right after the final accept.
    task automatic end_line(input int exp_done, input string name);
        req_in = '0;
        @(negedge pclk);
        check({name, "_grant_in_done"}, {30'b0, grant_out}, 32'd0);
        @(negedge pclk);
        check({name, "_busy_after"}, {31'b0, busy_out}, 32'd0);
        check({name, "_done_count"}, done_count, exp_done);
        @(posedge pclk); #1;
    endtask

    task automatic hold_idle_line(input int cycles, output bit seen_ready);
        seen_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            char_valid_in = '1;
            char_data_in  = {N{8'h5A}};
            @(negedge pclk);
            if (char_ready_out) seen_ready = 1'b1;
            @(posedge pclk); #1;
        end
        char_valid_in = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_in = '0;
        char_valid_in = '0;
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;

        // Reset state
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_grant", {30'b0, grant_out}, 32'd0);
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_busy", {31'b0, busy_out}, 32'd0);
        check("rst_done", {31'b0, done_out}, 32'd0);
        check("rst_ready", {31'b0, char_ready_out}, 32'd0);
        @(posedge pclk); #1 rst = 1'b0;

        // Single requester, steady vblank; WAIT_BLANK lasts one cycle
        vblnk_in = 1'b1;
        req_in   = 2'b01;
        wait_grant(2'b01, "t1_grant");
        @(negedge pclk);
        check("t1_ready_after_wait", {31'b0, char_ready_out}, 32'd1);
        @(posedge pclk); #1;
        stream(0, 0, LC, 1'b0);
        end_line(1, "t1");

        // Both requesting from reset: grants alternate 01, 10, 01
        do_reset();
        req_in = 2'b11;
        wait_grant(2'b01, "t2_grant_a");
        stream(0, 0, LC, 1'b0);
        wait_grant(2'b10, "t2_grant_b");
        stream(1, 0, LC, 1'b0);
        wait_grant(2'b01, "t2_grant_c");
        stream(0, 0, LC, 1'b0);
        end_line(4, "t2");

        // Grant outside vblank: nothing written until vblank rises
        vblnk_in = 1'b0;
        req_in   = 2'b01;
        wait_grant(2'b01, "t3_grant");
        hold_idle_line(50, seen);
        check("t3_ready_before_vblank", {31'b0, seen}, 32'd0);
        vblnk_in = 1'b1;
        stream(0, 0, LC, 1'b0);
        end_line(5, "t3");

        // Vblank falls after 12 characters, returns 100 cycles later
        req_in = 2'b01;
        wait_grant(2'b01, "t4_grant");
        stream(0, 0, 12, 1'b0);
        vblnk_in = 1'b0;
        hold_idle_line(100, seen);
        check("t4_ready_in_stall", {31'b0, seen}, 32'd0);
        vblnk_in = 1'b1;
        stream(0, 12, LC - 12, 1'b0);
        end_line(6, "t4");

        // Valid toggling every cycle keeps addresses contiguous
        req_in = 2'b01;
        wait_grant(2'b01, "t5_grant");
        stream(0, 0, LC, 1'b1);
        end_line(7, "t5");

        // Abort after 5 characters: no done, pointer stays on requester 0
        do_reset();
        req_in = 2'b01;
        wait_grant(2'b01, "t6_grant");
        stream(0, 0, 5, 1'b0);
        req_in = 2'b00;
        @(negedge pclk);
        @(negedge pclk);
        check("t6_grant_after_abort", {30'b0, grant_out}, 32'd0);
        check("t6_busy_after_abort", {31'b0, busy_out}, 32'd0);
        check("t6_no_done", done_count, 7);
        @(posedge pclk); #1;
        req_in = 2'b11;
        wait_grant(2'b01, "t6_ptr_unchanged");
        req_in = 2'b00;
        @(negedge pclk);
        @(negedge pclk);
        check("t6_grant_after_abort2", {30'b0, grant_out}, 32'd0);
        @(posedge pclk); #1;

        // Reset mid-line with valid still asserted: no further writes
        req_in = 2'b01;
        wait_grant(2'b01, "t7_grant");
        stream(0, 0, 7, 1'b0);
        char_valid_in = '1;
        char_data_in  = {N{8'h77}};
        rst = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        check("t7_rst_grant", {30'b0, grant_out}, 32'd0);
        check("t7_rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("t7_rst_wr_addr", {27'b0, wr_addr}, 32'd0);
        check("t7_rst_wr_data", {24'b0, wr_data}, 32'd0);
        check("t7_rst_busy", {31'b0, busy_out}, 32'd0);
        check("t7_rst_ready", {31'b0, char_ready_out}, 32'd0);
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b0;
        req_in = '0;
        char_valid_in = '0;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_done_count", done_count, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
